alu_operand_ctrl: RTL

Parametrised ALU operand-select and forwarding controller for the RISC-V pipeline. It is the successor to the single-bit ALU B-select decode: it decodes the instruction in decode (ID) and registers both ALU operand selects (A and B) into the execute (EX) stage. It tracks the destination registers of the last NUM_FWD_STAGES issued instructions, produces forwarding selects with stage indices, and detects load-use hazards, generating a stall and a bubble.

---
 rtl/alu_operand_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/alu_operand_ctrl.sv
// alu_operand_ctrl: decodes ALU operand selects in ID, tracks in-flight destinations for forwarding and detects load-use hazards.
module alu_operand_ctrl #(
    parameter int NUM_FWD_STAGES = 2,
    parameter bit ENABLE_FWD = 1'b1,
    localparam int STAGE_W = NUM_FWD_STAGES > 1 ? $clog2(NUM_FWD_STAGES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        id_inst,
    input  logic               id_valid,
    input  logic               stall_in,
    input  logic               flush,
    output logic               hazard_stall,
    output logic               ex_valid,
    output logic [1:0]         ex_a_sel,
    output logic [1:0]         ex_b_sel,
    output logic [STAGE_W-1:0] ex_rs1_fwd_stage,
    output logic               ex_rs2_fwd,
    output logic [STAGE_W-1:0] ex_rs2_fwd_stage
);
    logic [6:0] op;
    logic [4:0] rd, rs1, rs2;
    logic is_r, is_iar, is_ld, is_st, is_br, is_jalr, is_jal, is_lui, is_aui, is_csr;
    logic reads_rs1, reads_rs2, writes_rd, imm_b;
    logic hit1, hit2, ld1, ld2, hazard, issue, fwd1, fwd2;
    logic [STAGE_W-1:0] k1, k2;
    logic [1:0] a_dec, b_dec;
    logic unused_bits;
    logic ex_valid_q, ex_valid_d, ex_rs2_fwd_q, ex_rs2_fwd_d;
    logic [1:0] a_sel_q, a_sel_d, b_sel_q, b_sel_d;
    logic [STAGE_W-1:0] st1_q, st1_d, st2_q, st2_d;
    logic [NUM_FWD_STAGES-1:0] hv_q, hv_d, hld_q, hld_d;
    logic [NUM_FWD_STAGES-1:0][4:0] hrd_q, hrd_d;

    assign op      = id_inst[6:0];
    assign rd      = id_inst[11:7];
    assign rs1     = id_inst[19:15];
    assign rs2     = id_inst[24:20];
    assign is_r    = op == 7'b0110011;
    assign is_iar  = op == 7'b0010011;
    assign is_ld   = op == 7'b0000011;
    assign is_st   = op == 7'b0100011;
    assign is_br   = op == 7'b1100011;
    assign is_jalr = op == 7'b1100111;
    assign is_jal  = op == 7'b1101111;
    assign is_lui  = op == 7'b0110111;
    assign is_aui  = op == 7'b0010111;
    assign is_csr  = op == 7'b1110011;
    assign unused_bits = ^{id_inst[31:25], id_inst[13:12]};

    assign reads_rs1 = is_r | is_iar | is_ld | is_st | is_br | is_jalr | (is_csr & ~id_inst[14]);
    assign reads_rs2 = is_r | is_st | is_br;
    assign writes_rd = is_r | is_iar | is_ld | is_lui | is_aui | is_jal | is_jalr | is_csr;
    assign imm_b     = is_iar | is_lui | is_aui | is_jal | is_jalr | is_br | is_st | is_ld | is_csr;

    // Scan oldest to youngest so the youngest matching producer wins.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        ld1  = 1'b0;
        ld2  = 1'b0;
        k1   = '0;
        k2   = '0;
        for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
            if (reads_rs1 && rs1 != 5'd0 && hv_q[k] && hrd_q[k] == rs1) begin
                hit1 = 1'b1;
                k1   = STAGE_W'(k);
                ld1  = hld_q[k];
            end
            if (reads_rs2 && rs2 != 5'd0 && hv_q[k] && hrd_q[k] == rs2) begin
                hit2 = 1'b1;
                k2   = STAGE_W'(k);
                ld2  = hld_q[k];
            end
        end
    end

    assign hazard = ENABLE_FWD ? ((hit1 && k1 == '0 && ld1) || (hit2 && k2 == '0 && ld2)) : (hit1 || hit2);
    assign hazard_stall = id_valid & hazard & ~flush;
    assign issue = id_valid & ~hazard & ~flush;
    assign fwd1  = ENABLE_FWD && hit1;
    assign fwd2  = ENABLE_FWD && hit2;
    assign a_dec = (is_aui | is_jal | is_br) ? 2'b01 : fwd1 ? 2'b10 : 2'b00;
    assign b_dec = imm_b ? 2'b01 : fwd2 ? 2'b10 : 2'b00;

    always_comb begin
        ex_valid_d   = ex_valid_q;
        a_sel_d      = a_sel_q;
        b_sel_d      = b_sel_q;
        st1_d        = st1_q;
        ex_rs2_fwd_d = ex_rs2_fwd_q;
        st2_d        = st2_q;
        hv_d         = hv_q;
        hld_d        = hld_q;
        hrd_d        = hrd_q;
        if (!stall_in) begin
            ex_valid_d   = issue;
            a_sel_d      = issue ? a_dec : 2'b00;
            b_sel_d      = issue ? b_dec : 2'b00;
            st1_d        = (issue && fwd1) ? k1 : '0;
            ex_rs2_fwd_d = issue && fwd2;
            st2_d        = (issue && fwd2) ? k2 : '0;
            for (int k = NUM_FWD_STAGES - 1; k > 0; k--) begin
                hv_d[k]  = hv_q[k-1] & ~flush;
                hld_d[k] = hld_q[k-1];
                hrd_d[k] = hrd_q[k-1];
            end
            hv_d[0]  = issue & writes_rd;
            hld_d[0] = is_ld;
            hrd_d[0] = rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            a_sel_q      <= 2'b00;
            b_sel_q      <= 2'b00;
            st1_q        <= '0;
            ex_rs2_fwd_q <= 1'b0;
            st2_q        <= '0;
            hv_q         <= '0;
            hld_q        <= '0;
            hrd_q        <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            a_sel_q      <= a_sel_d;
            b_sel_q      <= b_sel_d;
            st1_q        <= st1_d;
            ex_rs2_fwd_q <= ex_rs2_fwd_d;
            st2_q        <= st2_d;
            hv_q         <= hv_d;
            hld_q        <= hld_d;
            hrd_q        <= hrd_d;
        end
    end

    assign ex_valid         = ex_valid_q;
    assign ex_a_sel         = a_sel_q;
    assign ex_b_sel         = b_sel_q;
    assign ex_rs1_fwd_stage = st1_q;
    assign ex_rs2_fwd       = ex_rs2_fwd_q;
    assign ex_rs2_fwd_stage = st2_q;
endmodule
